// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults and complex-number types for the FFT datapath.
// Index [0] is the real part and [1] the imaginary part of every complex bus.
package fft_pkg;

   localparam int FFT_DATA_WIDTH = 16;
   localparam int FFT_FRAC_BITS  = 15;

   localparam int RE = 0;
   localparam int IM = 1;

   typedef logic [1:0][FFT_DATA_WIDTH-1:0] cplx_t;
   typedef logic [1:0][FFT_FRAC_BITS:0]    twid_t;

endpackage

// File: rtl/cmul_conj.sv
// cmul_conj: stages S2 and S3 of the DIF butterfly. S2 forms the four
// full-precision products of the halved difference and the twiddle; S3
// combines them (conjugate selected by add/subtract sign), shifts right by
// FRAC_BITS and wraps to DATA_WIDTH.
// Optional macro DIF_BFLY_ROUND_EN: add 2^(FRAC_BITS-1) before the shift.
module cmul_conj
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int FRAC_BITS  = FFT_FRAC_BITS
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       s2_en_i,
   input  logic                       s3_en_i,
   input  logic [1:0][DATA_WIDTH-1:0] diff_i,
   input  logic [1:0][FRAC_BITS:0]    twid_i,
   input  logic                       inv_i,
   output logic [1:0][DATA_WIDTH-1:0] res_o
);

   localparam int PW = DATA_WIDTH + FRAC_BITS + 1;   // product width
   localparam int CW = PW + 1;                       // combined width
`ifdef DIF_BFLY_ROUND_EN
   localparam logic signed [CW-1:0] RND = CW'(1) << (FRAC_BITS - 1);
`endif

   logic signed [PW-1:0]       d_re, d_im, w_re, w_im;
   logic signed [PW-1:0]       rr_d, ii_d, ri_d, ir_d;
   logic signed [PW-1:0]       rr_q, ii_q, ri_q, ir_q;
   logic                       inv2_d, inv2_q;
   logic signed [CW-1:0]       re_c, im_c;
   logic [1:0][DATA_WIDTH-1:0] res_d, res_q;

   // S2: sign-extend operands to product width and form the four products
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      rr_d   = rr_q;
      ii_d   = ii_q;
      ri_d   = ri_q;
      ir_d   = ir_q;
      inv2_d = inv2_q;
      d_re   = PW'($signed(diff_i[RE]));
      d_im   = PW'($signed(diff_i[IM]));
      w_re   = PW'($signed(twid_i[RE]));
      w_im   = PW'($signed(twid_i[IM]));
      if (s2_en_i) begin
         rr_d   = d_re * w_re;
         ii_d   = d_im * w_im;
         ri_d   = d_re * w_im;
         ir_d   = d_im * w_re;
         inv2_d = inv_i;
      end
   end

   // S3: conjugate by choosing the add/subtract sign, never by negating W
   always_comb begin
      res_d = res_q;
      if (inv2_q) begin
         re_c = CW'(rr_q) + CW'(ii_q);
         im_c = CW'(ir_q) - CW'(ri_q);
      end else begin
         re_c = CW'(rr_q) - CW'(ii_q);
         im_c = CW'(ri_q) + CW'(ir_q);
      end
`ifdef DIF_BFLY_ROUND_EN
      re_c = re_c + RND;
      im_c = im_c + RND;
`endif
      if (s3_en_i) begin
         res_d[RE] = DATA_WIDTH'(re_c >>> FRAC_BITS);
         res_d[IM] = DATA_WIDTH'(im_c >>> FRAC_BITS);
      end
   end

   // Product and result registers
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      // NOTE: data registers are reset as well, so outputs read 0 after reset instead of stale data.
      if (!rst_ni) begin
         rr_q   <= '0;
         ii_q   <= '0;
         ri_q   <= '0;
         ir_q   <= '0;
         inv2_q <= 1'b0;
         res_q  <= '0;
      end else begin
         rr_q   <= rr_d;
         ii_q   <= ii_d;
         ri_q   <= ri_d;
         ir_q   <= ir_d;
         inv2_q <= inv2_d;
         res_q  <= res_d;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/dif_butterfly_pipe.sv
// dif_butterfly_pipe: 3-stage pipelined Gentleman-Sande (DIF) radix-2
// butterfly with valid/ready flow control and collapsing bubbles.
//   a_o = (a+b)/2,  b_o = ((a-b)/2) * W   (conj(W) when inv_i=1)
// Optional macro DIF_BFLY_ROUND_EN: round half up instead of truncating.
module dif_butterfly_pipe
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DATA_WIDTH,
   parameter int FRAC_BITS  = FFT_FRAC_BITS
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [1:0][DATA_WIDTH-1:0] a_i,
   input  logic [1:0][DATA_WIDTH-1:0] b_i,
   input  logic [1:0][FRAC_BITS:0]    twid_i,
   input  logic                       inv_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [1:0][DATA_WIDTH-1:0] a_o,
   output logic [1:0][DATA_WIDTH-1:0] b_o
);

   logic adv1, adv2, adv3, acc, ld1, ld2, ld3;
   logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;

   logic signed [DATA_WIDTH:0] sum_w [2];
   logic signed [DATA_WIDTH:0] diff_w [2];

   logic [1:0][DATA_WIDTH-1:0] sum1_d, sum1_q, diff1_d, diff1_q;
   logic [1:0][FRAC_BITS:0]    w1_d, w1_q;
   logic                       inv1_d, inv1_q;
   logic [1:0][DATA_WIDTH-1:0] sum2_d, sum2_q, a3_d, a3_q;

   // Flow control: a stage advances when empty or when the next one advances
   always_comb begin
      adv3 = !v3_q || ready_i;
      adv2 = !v2_q || adv3;
      adv1 = !v1_q || adv2;
      acc  = valid_i && ready_o;
      ld1  = adv1 && acc;
      ld2  = adv2 && v1_q;
      ld3  = adv3 && v2_q;
      v1_d = adv1 ? acc  : v1_q;
      v2_d = adv2 ? v1_q : v2_q;
      v3_d = adv3 ? v2_q : v3_q;
   end

   assign ready_o = rst_ni && adv1;

   // S1: widen by one bit, add/subtract, keep bits [DATA_WIDTH:1] (halving)
   always_comb begin
      sum1_d  = sum1_q;
      diff1_d = diff1_q;
      w1_d    = w1_q;
      inv1_d  = inv1_q;
      for (int k = 0; k < 2; k++) begin
         sum_w[k]  = (DATA_WIDTH+1)'($signed(a_i[k])) + (DATA_WIDTH+1)'($signed(b_i[k]));
         diff_w[k] = (DATA_WIDTH+1)'($signed(a_i[k])) - (DATA_WIDTH+1)'($signed(b_i[k]));
`ifdef DIF_BFLY_ROUND_EN
         sum_w[k]  = sum_w[k] + (DATA_WIDTH+1)'(1);
         diff_w[k] = diff_w[k] + (DATA_WIDTH+1)'(1);
`endif
      end
      if (ld1) begin
         for (int k = 0; k < 2; k++) begin
            sum1_d[k]  = DATA_WIDTH'(sum_w[k] >>> 1);
            diff1_d[k] = DATA_WIDTH'(diff_w[k] >>> 1);
         end
         w1_d   = twid_i;
         inv1_d = inv_i;
      end
   end

   // S2/S3: delay the halved sum so a_o lines up with the rotated difference
   always_comb begin
      sum2_d = ld2 ? sum1_q : sum2_q;
      a3_d   = ld3 ? sum2_q : a3_q;
   end

   // Valid bits and upper-path data registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         sum1_q  <= '0;
         diff1_q <= '0;
         w1_q    <= '0;
         inv1_q  <= 1'b0;
         sum2_q  <= '0;
         a3_q    <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         sum1_q  <= sum1_d;
         diff1_q <= diff1_d;
         w1_q    <= w1_d;
         inv1_q  <= inv1_d;
         sum2_q  <= sum2_d;
         a3_q    <= a3_d;
      end
   end

   cmul_conj #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_cmul (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .s2_en_i (ld2),
      .s3_en_i (ld3),
      .diff_i  (diff1_q),
      .twid_i  (w1_q),
      .inv_i   (inv1_q),
      .res_o   (b_o)
   );

   assign valid_o = v3_q;
   assign a_o     = a3_q;

endmodule

// File: tb/tb_dif_butterfly_pipe.sv
// tb_dif_butterfly_pipe: directed self-checking bench for dif_butterfly_pipe
// (DATA_WIDTH=16, FRAC_BITS=15). Expected values are hand-computed; the
// DIF_BFLY_ROUND_EN macro selects the rounded expectations where they differ.
module tb_dif_butterfly_pipe;
   import fft_pkg::*;

`ifdef DIF_BFLY_ROUND_EN
   localparam int EB022  = 400;
   localparam int MIX_AR = -2;
   localparam int MIX_AI = 1;
   localparam int MIX_BR = -4;
   localparam int MIX_BI = 1;
`else
   localparam int EB022  = 399;
   localparam int MIX_AR = -3;
   localparam int MIX_AI = 0;
   localparam int MIX_BR = -5;
   localparam int MIX_BI = -1;
`endif

   logic  clk_i = 1'b0;
   logic  rst_ni, valid_i, ready_o, inv_i, valid_o, ready_i;
   cplx_t a_i, b_i, a_o, b_o;
   twid_t twid_i;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   dif_butterfly_pipe dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .twid_i  (twid_i),
      .inv_i   (inv_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .a_o     (a_o),
      .b_o     (b_o)
   );

   function automatic cplx_t cx(input int re, input int im);
      cplx_t c;
      c[0] = 16'(re);
      c[1] = 16'(im);
      return c;
   endfunction

   function automatic twid_t tw(input int re, input int im);
      twid_t t;
      t[0] = 16'(re);
      t[1] = 16'(im);
      return t;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One isolated beat: accepted at edge E0, valid_o must rise after E2
   task automatic beat(input string tag, input cplx_t a, input cplx_t b, input twid_t w,
                       input logic inv, input cplx_t ea, input cplx_t eb);
      @(negedge clk_i);
      a_i = a; b_i = b; twid_i = w; inv_i = inv; valid_i = 1'b1;
      #1;
      check({tag, ":ready"}, 32'(ready_o), 32'd1);
      @(negedge clk_i);
      valid_i = 1'b0;
      check({tag, ":lat1"}, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      check({tag, ":lat2"}, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      check({tag, ":lat3"}, 32'(valid_o), 32'd1);
      check({tag, ":a_o"}, a_o, ea);
      check({tag, ":b_o"}, b_o, eb);
   endtask

   initial begin
      int    nin;
      int    nout;
      int    stall_left;
      bit    stalled_once;

      rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; inv_i = 1'b0;
      a_i = '0; b_i = '0; twid_i = '0;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst:valid_o", 32'(valid_o), 32'd0);
      check("rst:ready_o", 32'(ready_o), 32'd0);
      check("rst:a_o", a_o, 32'd0);
      check("rst:b_o", b_o, 32'd0);
      rst_ni = 1'b1;

      // Directed single beats
      beat("real_w", cx(1000, 0), cx(200, 0), tw(32767, 0), 1'b0, cx(600, 0), cx(EB022, 0));
      beat("minus_j_fwd", cx(1000, 0), cx(200, 0), tw(0, -32768), 1'b0, cx(600, 0), cx(0, -400));
      beat("minus_j_inv", cx(1000, 0), cx(200, 0), tw(0, -32768), 1'b1, cx(600, 0), cx(0, 400));
      beat("full_neg", cx(-32768, -32768), cx(-32768, -32768), tw(32767, 0), 1'b0,
           cx(-32768, -32768), cx(0, 0));
      beat("mixed", cx(-7, 5), cx(2, -4), tw(16384, 16384), 1'b0,
           cx(MIX_AR, MIX_AI), cx(MIX_BR, MIX_BI));

      // Stream of 6 beats with a 5-cycle downstream stall at the first output.
      // Beat k: a=(100k,0), b=0, W=-j, inv=1 -> a_o=(50k,0), b_o=(0,50k).
      nin = 0; nout = 0; stall_left = 0; stalled_once = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_i);
         ready_i = (stall_left == 0);
         #1;
         if (valid_o && !stalled_once) begin
            stalled_once = 1'b1;
            stall_left   = 5;
            ready_i      = 1'b0;
            #1;
         end
         if (stall_left > 0) begin
            check("stall:valid_o", 32'(valid_o), 32'd1);
            check("stall:ready_o", 32'(ready_o), 32'd0);
            check("stall:a_o", a_o, cx(50, 0));
            check("stall:b_o", b_o, cx(0, 50));
            stall_left--;
         end else if (valid_o) begin
            nout++;
            check("stream:a_o", a_o, cx(50 * nout, 0));
            check("stream:b_o", b_o, cx(0, 50 * nout));
         end
         if (nin < 6) begin
            valid_i = 1'b1;
            a_i = cx(100 * (nin + 1), 0); b_i = cx(0, 0);
            twid_i = tw(0, -32768); inv_i = 1'b1;
            if (ready_o) nin++;
         end else begin
            valid_i = 1'b0;
         end
      end
      check("stream:count", 32'(nout), 32'd6);
      check("stream:stalled", 32'(stalled_once), 32'd1);

      // Reset pulse mid-stream: beats a=(200k,0) -> a_o=(100k,0), b_o=(0,100k)
      ready_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_i);
         valid_i = 1'b1;
         a_i = cx(200 * k, 0); b_i = cx(0, 0); twid_i = tw(0, -32768); inv_i = 1'b1;
      end
      @(negedge clk_i);
      #1;
      check("midrst:pre_valid", 32'(valid_o), 32'd1);
      rst_ni = 1'b0;
      a_i = cx(800, 0);
      @(negedge clk_i);
      check("midrst:valid_o", 32'(valid_o), 32'd0);
      check("midrst:a_o", a_o, 32'd0);
      check("midrst:b_o", b_o, 32'd0);
      check("midrst:ready_o", 32'(ready_o), 32'd0);
      rst_ni = 1'b1;
      a_i = cx(1400, 0);
      #1;
      check("midrst:ready_rel", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("midrst:lat1", 32'(valid_o), 32'd0);
      @(negedge clk_i);
      check("midrst:lat2", 32'(valid_o), 32'd0);
      @(negedge clk_i);
      check("midrst:lat3", 32'(valid_o), 32'd1);
      check("midrst:a_o_new", a_o, cx(700, 0));
      check("midrst:b_o_new", b_o, cx(0, 700));
      @(negedge clk_i);
      check("midrst:drain", 32'(valid_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
